mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Sits directly downstream of the pipeline core's data-memory port: Addr_out, Data_out, mem_w, MEMOp and loadSignExt.
- Adds byte and halfword load/store support on top of a word-only data memory with a ready handshake. Sub-word stores use read-modify-write.
- Returns lane-aligned, zero- or sign-extended load data.
- Drives a busy stall back to the core.

Parameters:
- ADDR_W, 32, byte-address width for request and memory address.
- DATA_W, 32, data width; fixed at 32 (4 byte lanes).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  access request from the core (level, held while busy).
- req_we  in  1  1 = store, 0 = load.
- req_op  in  2  access size: 00 word, 01 halfword, 10 byte; 11 is treated as word.
- req_sext  in  1  load extension: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; the sub-word value is in the low bits.
- busy  out  1  stall to the core.
- rdata  out  32  extended load result.
- rdata_valid  out  1  one-cycle pulse when rdata is updated.
- misalign  out  1  one-cycle pulse on a rejected misaligned request.
- mem_req  out  1  memory access request.
- mem_we  out  1  memory write enable (only meaningful with mem_req).
- mem_addr  out  ADDR_W  word address {addr[ADDR_W-1:2], 2'b00}.
- mem_wdata  out  32  full word to write.
- mem_rdata  in  32  memory read data; valid when mem_ready is high during a read.
- mem_ready  in  1  memory completes the current access at the rising edge where mem_req && mem_ready.

Behaviour:
- Reset: the one clock is clk; reset is asynchronous and active-low.
  - While reset=0: state=IDLE; busy, rdata_valid, misalign, mem_req and mem_we = 0; rdata, mem_addr and mem_wdata = 0.
  - Reset mid-access drops mem_req immediately; the pending access is abandoned with no rdata_valid.
- Misalignment check, done in IDLE:
  - Word access with addr[1:0] != 0 is misaligned.
  - Halfword access with addr[0] = 1 is misaligned.
  - A misaligned request pulses misalign for the next cycle, issues no memory access and stays IDLE.
- State machine, states IDLE, RD, RMW_RD, RMW_WR, WR:
  - IDLE + aligned req_valid: latch addr/op/sext/wdata, then
    - load -> RD;
    - word store -> WR;
    - byte/half store -> RMW_RD.
  - RD: mem_req=1, mem_we=0. On mem_ready, register the extracted value into rdata, pulse rdata_valid next cycle, go to IDLE.
  - RMW_RD: mem_req=1, mem_we=0. On mem_ready, merge the store lane(s) into mem_rdata, register the result as mem_wdata, go to RMW_WR.
  - RMW_WR: mem_req=1, mem_we=1. On mem_ready, go to IDLE.
  - WR: mem_req=1, mem_we=1, mem_wdata=req_wdata. On mem_ready, go to IDLE.
  - mem_req, mem_we, mem_addr and mem_wdata are held stable until mem_ready is sampled high. Waiting for mem_ready is unbounded.
- busy = (state != IDLE) | (req_valid & ~misaligned_now). This is combinational so the core freezes in the accept cycle. busy drops in the cycle the FSM returns to IDLE.
- req_valid while state != IDLE is ignored; the core holds it under stall, and the held request is not re-accepted.
  - On returning to IDLE, a request is re-accepted only after req_valid deasserts once.
  - For a back-to-back new request, the core must drop req_valid for at least one cycle.
- Lanes are little-endian:
  - byte lane k = addr[1:0] maps to bits [8k+7:8k];
  - half lane addr[1] maps to bits [16*addr[1]+15 : 16*addr[1]].
- Extension: sign-extend from bit 7 (byte) or bit 15 (half) when sext=1, else zero-fill. A word load ignores sext.
- RMW merge replaces only the addressed lane(s); all other bytes come from mem_rdata.
- Latency with mem_ready tied high:
  - load / word store: 2 cycles busy;
  - sub-word store: 3 cycles busy;
  - rdata_valid asserts in the cycle after the RD completion edge.
- rdata holds its value until the next completed load.

Test Plan:
- Word load, addr 0x0000_0010, mem word 0xDEAD_BEEF, mem_ready=1 -> mem_addr=0x10, rdata=0xDEADBEEF, one rdata_valid pulse, busy high for 2 cycles.
- Byte load, addr 0x13, word 0x8012_3456:
  - sext=1 -> rdata=0xFFFF_FF80;
  - repeat with sext=0 -> rdata=0x0000_0080.
- Halfword store 0x0000_ABCD to addr 0x22, memory word 0x1111_1111 -> one read then one write to 0x20; mem_wdata=0xABCD_1111; busy for 3 cycles.
- Misaligned word load at 0x06 and misaligned halfword store at 0x05 -> misalign pulses once each; mem_req never asserts; memory unchanged.
- Byte store 0x5A to 0x41 with mem_ready low for 4 cycles in both RMW_RD and RMW_WR -> mem_req/mem_addr=0x40 held stable; final word has 0x5A in bits[15:8] and other bytes unchanged; busy covers the whole stall.
- reset low while in RMW_RD waiting -> mem_req falls asynchronously, state IDLE, no write issued; after release a word load at 0x10 completes normally.

Source files
------------

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// =============================================================================
// mem_access_unit_if : core request / data-memory bus between core and MAU
// Rev 1.0 - initial release
// =============================================================================
interface mem_access_unit_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req_valid;
   logic              req_we;
   logic [1:0]        req_op;
   logic              req_sext;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              busy;
   logic [DATA_W-1:0] rdata;
   logic              rdata_valid;
   logic              misalign;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;

   // slave: the access unit itself
   modport slave (
      input  req_valid, req_we, req_op, req_sext, req_addr, req_wdata,
      input  mem_rdata, mem_ready,
      output busy, rdata, rdata_valid, misalign,
      output mem_req, mem_we, mem_addr, mem_wdata
   );

   // master: core plus data memory
   modport master (
      output req_valid, req_we, req_op, req_sext, req_addr, req_wdata,
      output mem_rdata, mem_ready,
      input  busy, rdata, rdata_valid, misalign,
      input  mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// =============================================================================
// mem_access_unit : byte/half/word load-store front end for a word-only memory
// Rev 1.0 - initial release
// =============================================================================
module mem_access_unit #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   mem_access_unit_if.slave    bus
);
   localparam logic [2:0] c_IDLE   = 3'd0;
   localparam logic [2:0] c_RD     = 3'd1;
   localparam logic [2:0] c_RMW_RD = 3'd2;
   localparam logic [2:0] c_RMW_WR = 3'd3;
   localparam logic [2:0] c_WR     = 3'd4;

   localparam logic [1:0] c_OP_HALF = 2'b01;
   localparam logic [1:0] c_OP_BYTE = 2'b10;

   logic [2:0]        r_state;
   logic              r_armed;
   logic [ADDR_W-1:0] r_addr;
   logic [1:0]        r_op;
   logic              r_sext;
   logic [15:0]       r_sdata;
   logic [DATA_W-1:0] r_rdata;
   logic [DATA_W-1:0] r_wdata;
   logic              r_rdata_valid;
   logic              r_misalign;

   logic              w_req_half;
   logic              w_req_byte;
   logic              w_misaligned;
   logic              w_idle;
   logic              w_present;
   logic              w_accept;
   logic              w_reject;
   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic [DATA_W-1:0] w_load_val;
   logic [DATA_W-1:0] w_merged;

   assign w_req_half   = (bus.req_op == c_OP_HALF);
   assign w_req_byte   = (bus.req_op == c_OP_BYTE);
   assign w_misaligned = (~w_req_half & ~w_req_byte & (bus.req_addr[1:0] != 2'b00))
                       | (w_req_half & bus.req_addr[0]);
   assign w_idle       = (r_state == c_IDLE);
   // A held request is only seen again after req_valid has dropped once
   assign w_present    = bus.req_valid & r_armed;
   assign w_accept     = w_idle & w_present & ~w_misaligned;
   assign w_reject     = w_idle & w_present & w_misaligned;

   assign bus.busy        = reset & (~w_idle | (w_present & ~w_misaligned));
   assign bus.mem_req     = ~w_idle;
   assign bus.mem_we      = (r_state == c_RMW_WR) | (r_state == c_WR);
   assign bus.mem_addr    = {r_addr[ADDR_W-1:2], 2'b00};
   assign bus.mem_wdata   = r_wdata;
   assign bus.rdata       = r_rdata;
   assign bus.rdata_valid = r_rdata_valid;
   assign bus.misalign    = r_misalign;

   always_comb begin
      w_byte     = bus.mem_rdata[{r_addr[1:0], 3'b000} +: 8];
      w_half     = r_addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
      w_load_val = bus.mem_rdata;
      if (r_op == c_OP_BYTE)
         w_load_val = {{24{r_sext & w_byte[7]}}, w_byte};
      else if (r_op == c_OP_HALF)
         w_load_val = {{16{r_sext & w_half[15]}}, w_half};

      w_merged = bus.mem_rdata;
      if (r_op == c_OP_BYTE)
         w_merged[{r_addr[1:0], 3'b000} +: 8] = r_sdata[7:0];
      else
         w_merged[{r_addr[1], 4'b0000} +: 16] = r_sdata;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= c_IDLE;
         r_armed       <= 1'b1;
         r_addr        <= '0;
         r_op          <= 2'b00;
         r_sext        <= 1'b0;
         r_sdata       <= '0;
         r_rdata       <= '0;
         r_wdata       <= '0;
         r_rdata_valid <= 1'b0;
         r_misalign    <= 1'b0;
      end else begin
         r_rdata_valid <= 1'b0;
         r_misalign    <= w_reject;
         if (!bus.req_valid)
            r_armed <= 1'b1;

         case (r_state)
            c_IDLE: begin
               if (w_accept) begin
                  r_armed <= 1'b0;
                  r_addr  <= bus.req_addr;
                  r_op    <= bus.req_op;
                  r_sext  <= bus.req_sext;
                  r_sdata <= bus.req_wdata[15:0];
                  if (!bus.req_we)
                     r_state <= c_RD;
                  else if (w_req_half | w_req_byte)
                     r_state <= c_RMW_RD;
                  else begin
                     r_state <= c_WR;
                     r_wdata <= bus.req_wdata;
                  end
               end
            end
            c_RD: begin
               if (bus.mem_ready) begin
                  r_rdata       <= w_load_val;
                  r_rdata_valid <= 1'b1;
                  r_state       <= c_IDLE;
               end
            end
            c_RMW_RD: begin
               if (bus.mem_ready) begin
                  r_wdata <= w_merged;
                  r_state <= c_RMW_WR;
               end
            end
            c_RMW_WR, c_WR: begin
               if (bus.mem_ready)
                  r_state <= c_IDLE;
            end
            default: r_state <= c_IDLE;
         endcase
      end
   end
endmodule
`default_nettype wire
